// File: rtl/hash160_byte_loader.sv
// hash160_byte_loader
//   Byte-serial front end of the Hash160 datapath. Waits for START_BYTE on
//   the input stream, shifts the following NUM_BYTES bytes into a block
//   register and offers that block downstream with a valid/ready handshake.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   i_text         byte stream, sampled every edge
//   o_block        assembled block, first byte in the top bits
//   o_block_valid  a complete block is held
//   i_block_ready  downstream takes the block when valid & ready at an edge
//   o_busy         state is COLLECT or HOLD
//   o_drop         one-cycle pulse: a frame start was lost while holding
module hash160_byte_loader #(
  parameter logic [7:0] START_BYTE = 8'hAA,
  parameter int         NUM_BYTES  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_text,
  output logic [NUM_BYTES*8-1:0] o_block,
  output logic                   o_block_valid,
  input  logic                   i_block_ready,
  output logic                   o_busy,
  output logic                   o_drop
);

  localparam int CW = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [NUM_BYTES*8-1:0] r_block;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_drop;

  logic w_start;
  assign w_start = (i_text == START_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_block <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_COLLECT: begin
          // Every byte in the frame is data, including START_BYTE values.
          r_block <= {r_block[NUM_BYTES*8-9:0], i_text};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_HOLD;
            r_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_block_ready) begin
            r_valid <= 1'b0;
            // A marker on the handshake edge opens the next frame directly.
            if (w_start) begin
              r_state <= S_COLLECT;
              r_cnt   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_start) begin
            // No room for a new frame: flag it and keep holding.
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_block       = r_block;
  assign o_block_valid = r_valid;
  assign o_busy        = r_busy;
  assign o_drop        = r_drop;

endmodule
